// File: rtl/arb_pkg.sv
// Shared helpers for the round-robin burst arbiter.
// idx_w gives the width of a requester index (never narrower than one bit).
package arb_pkg;

   function automatic int idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating find-first: returns the first set req bit at or after start, wrapping.
module rr_priority_pick
   import arb_pkg::*;
#(
   parameter int N_REQ = 2
) (
   input  logic [N_REQ-1:0]        req,
   input  logic [idx_w(N_REQ)-1:0] start,
   output logic [idx_w(N_REQ)-1:0] gnt_idx,
   output logic                    gnt_any
);

   localparam int IW = idx_w(N_REQ);

   int w_idx;

   // Scan from the farthest offset back to start so the nearest match wins
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      w_idx   = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_idx = (int'(start) + k) % N_REQ;
         if (req[w_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = IW'(w_idx);
         end else begin
            gnt_any = gnt_any;
         end
      end
   end

endmodule

// File: rtl/rr_burst_arbiter.sv
// N-to-1 valid/ready merge with round-robin grant, burst locking up to MAX_BURST
// beats per owner, and a single registered output stage.
module rr_burst_arbiter
   import arb_pkg::*;
#(
   parameter int D_WIDTH   = 6,
   parameter int N_REQ     = 2,
   parameter int MAX_BURST = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ*D_WIDTH-1:0]   up_data,
   input  logic [N_REQ-1:0]           up_valid,
   output logic [N_REQ-1:0]           up_ready,
   output logic [D_WIDTH-1:0]         down_data,
   output logic [idx_w(N_REQ)-1:0]    down_src,
   output logic                       down_valid,
   input  logic                       down_ready
);

   localparam int              IW   = idx_w(N_REQ);
   localparam int              CW   = $clog2(MAX_BURST + 1);
   localparam logic [IW-1:0]   LAST = IW'(N_REQ - 1);
   localparam logic [CW-1:0]   CMAX = CW'(MAX_BURST);

   logic [D_WIDTH-1:0] r_data;
   logic [IW-1:0]      r_src;
   logic               r_valid;
   logic [IW-1:0]      r_owner;
   logic [CW-1:0]      r_cnt;

   logic               w_load_en;
   logic               w_lock;
   logic [IW-1:0]      w_start;
   logic [IW-1:0]      w_rr_idx;
   logic               w_rr_any;
   logic [IW-1:0]      w_grant;
   logic               w_any;
   logic               w_accept;
   logic [D_WIDTH-1:0] w_sel_data;

   assign w_load_en = !r_valid | down_ready;
   assign w_lock    = (r_cnt != '0) && (r_cnt < CMAX) && up_valid[r_owner];
   assign w_start   = (r_owner == LAST) ? '0 : r_owner + IW'(1);
   assign w_grant   = w_lock ? r_owner : w_rr_idx;
   assign w_any     = w_lock | w_rr_any;
   assign w_accept  = w_load_en & w_any;

   rr_priority_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req     (up_valid),
      .start   (w_start),
      .gnt_idx (w_rr_idx),
      .gnt_any (w_rr_any)
   );

   // Ready is one-hot on the grant and forced low while reset is held
   always_comb begin
      up_ready   = '0;
      w_sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_grant == IW'(i)) begin
            up_ready[i] = w_accept & !rst;
            w_sel_data  = up_data[i*D_WIDTH +: D_WIDTH];
         end else begin
            up_ready[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data  <= '0;
         r_src   <= '0;
         r_valid <= 1'b0;
         r_owner <= LAST;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_data  <= w_sel_data;
         r_src   <= w_grant;
         r_valid <= 1'b1;
         r_owner <= w_grant;
         // A re-grant after a full burst restarts the count at one
         r_cnt   <= (w_grant == r_owner && r_cnt < CMAX) ? r_cnt + CW'(1) : CW'(1);
      end else if (w_load_en) begin
         r_valid <= 1'b0;
      end
   end

   assign down_data  = r_data;
   assign down_src   = r_src;
   assign down_valid = r_valid;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench: default 2-requester arbiter plus a 4-requester pure round-robin instance.
module tb_rr_burst_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic [11:0] up_data;
   logic [1:0]  up_valid, up_ready;
   logic [5:0]  down_data;
   logic        down_src, down_valid, down_ready;

   logic [23:0] q_data;
   logic [3:0]  q_valid, q_ready;
   logic [5:0]  q_ddata;
   logic [1:0]  q_src;
   logic        q_dvalid, q_dready;

   int          n_vec = 0;
   int          n_err = 0;
   logic [5:0]  a_d, b_d;
   logic [1:0]  rdy;

   rr_burst_arbiter #(.D_WIDTH(6), .N_REQ(2), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst), .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
      .down_data(down_data), .down_src(down_src), .down_valid(down_valid), .down_ready(down_ready)
   );

   rr_burst_arbiter #(.D_WIDTH(6), .N_REQ(4), .MAX_BURST(1)) dut4 (
      .clk(clk), .rst(rst), .up_data(q_data), .up_valid(q_valid), .up_ready(q_ready),
      .down_data(q_ddata), .down_src(q_src), .down_valid(q_dvalid), .down_ready(q_dready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      up_data = {b_d, a_d};
      #1;
      rdy = up_ready;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rdy[0]) a_d = a_d + 6'd1;
      if (rdy[1]) b_d = b_d + 6'd1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      up_valid   = 2'b00;
      down_ready = 1'b1;
      q_valid    = 4'b0000;
      q_dready   = 1'b1;
      a_d        = 6'h01;
      b_d        = 6'h21;
      up_data    = {b_d, a_d};
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   logic [5:0] e1d [10] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h21, 6'h22, 6'h23, 6'h24, 6'h05, 6'h06};
   logic       e1s [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic [1:0] e6s [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};

   initial begin
      // reset state, with requests pending so ready gating is meaningful
      do_reset();
      rst      = 1'b1;
      up_valid = 2'b11;
      #1;
      chk("rst_valid", 32'(down_valid), 32'd0);
      chk("rst_data",  32'(down_data),  32'd0);
      chk("rst_src",   32'(down_src),   32'd0);
      chk("rst_ready", 32'(up_ready),   32'd0);
      rst = 1'b0;
      #1;
      chk("rst_first_ready", 32'(up_ready), 32'd1);

      // both valid: bursts of four alternate with no bubbles
      do_reset();
      up_valid = 2'b11;
      for (int i = 0; i < 10; i++) begin
         drive();
         tick();
         chk("t1_valid", 32'(down_valid), 32'd1);
         chk("t1_src",   32'(down_src),   32'(e1s[i]));
         chk("t1_data",  32'(down_data),  32'(e1d[i]));
      end

      // only requester 1: six beats straight through the re-grant
      do_reset();
      up_valid = 2'b10;
      b_d      = 6'h10;
      for (int i = 0; i < 6; i++) begin
         drive();
         tick();
         chk("t2_valid", 32'(down_valid), 32'd1);
         chk("t2_src",   32'(down_src),   32'd1);
         chk("t2_data",  32'(down_data),  32'(6'h10 + 6'(i)));
      end
      up_valid = 2'b00;
      drive();
      chk("t2_idle_ready", 32'(up_ready), 32'd0);
      tick();
      chk("t2_drain", 32'(down_valid), 32'd0);

      // backpressure while 0x03 is held
      do_reset();
      up_valid = 2'b11;
      for (int i = 0; i < 3; i++) begin
         drive();
         tick();
      end
      chk("t3_pre", 32'(down_data), 32'h03);
      down_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive();
         chk("t3_stall_ready", 32'(up_ready), 32'd0);
         tick();
         chk("t3_hold_data",  32'(down_data),  32'h03);
         chk("t3_hold_valid", 32'(down_valid), 32'd1);
         chk("t3_hold_src",   32'(down_src),   32'd0);
      end
      down_ready = 1'b1;
      drive();
      chk("t3_rel_ready", 32'(up_ready), 32'b01);
      tick();
      chk("t3_rel_data", 32'(down_data), 32'h04);
      drive();
      chk("t3_burst_end_ready", 32'(up_ready), 32'b10);
      tick();
      chk("t3_next_src",  32'(down_src),  32'd1);
      chk("t3_next_data", 32'(down_data), 32'h21);

      // owner drops mid-burst: B takes over and keeps a full burst
      do_reset();
      up_valid = 2'b11;
      for (int i = 0; i < 2; i++) begin
         drive();
         tick();
      end
      up_valid = 2'b10;
      drive();
      chk("t4_break_ready", 32'(up_ready), 32'b10);
      tick();
      chk("t4_b_src",  32'(down_src),  32'd1);
      chk("t4_b_data", 32'(down_data), 32'h21);
      up_valid = 2'b11;
      for (int i = 0; i < 3; i++) begin
         drive();
         chk("t4_lock_ready", 32'(up_ready), 32'b10);
         tick();
         chk("t4_lock_data", 32'(down_data), 32'(6'h22 + 6'(i)));
      end
      drive();
      chk("t4_a_ready", 32'(up_ready), 32'b01);
      tick();
      chk("t4_a_src",  32'(down_src),  32'd0);
      chk("t4_a_data", 32'(down_data), 32'h03);

      // reset asserted away from the clock edge mid-burst
      do_reset();
      up_valid = 2'b11;
      for (int i = 0; i < 2; i++) begin
         drive();
         tick();
      end
      chk("t5_pre_valid", 32'(down_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_async_valid", 32'(down_valid), 32'd0);
      chk("t5_async_data",  32'(down_data),  32'd0);
      chk("t5_async_ready", 32'(up_ready),   32'd0);
      #1;
      rst = 1'b0;
      drive();
      chk("t5_post_ready", 32'(up_ready), 32'b01);
      tick();
      chk("t5_post_src",  32'(down_src),  32'd0);
      chk("t5_post_data", 32'(down_data), 32'h03);

      // four requesters, MAX_BURST=1: pure rotation, then requester 2 drops out
      do_reset();
      q_data  = {6'h33, 6'h32, 6'h31, 6'h30};
      q_valid = 4'b1111;
      for (int i = 0; i < 10; i++) begin
         if (i == 5) q_valid = 4'b1011;
         @(posedge clk);
         #1;
         chk("t6_valid", 32'(q_dvalid), 32'd1);
         chk("t6_src",   32'(q_src),    32'(e6s[i]));
         chk("t6_data",  32'(q_ddata),  32'(6'h30 + 6'(e6s[i])));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rr_burst_arbiter.md
# rr_burst_arbiter

Merges `N_REQ` upstream valid/ready streams onto one downstream valid/ready stream. Grant rotation is round-robin with burst locking: the current owner keeps the grant for up to `MAX_BURST` consecutive beats. It has a one-entry registered output stage. It sits in front of a shared `ff_fifo_pow2_depth` so several producers can share one buffer without a join.

## Interface
- `D_WIDTH`, 6: payload width per beat.
- `N_REQ`, 2: number of requesters (≥2).
- `MAX_BURST`, 4: maximum consecutive beats per grant (≥1); 1 gives pure round-robin.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `up_data`  in  `N_REQ*D_WIDTH`: flat payloads; requester i occupies bits `[i*D_WIDTH +: D_WIDTH]`.
- `up_valid`  in  `N_REQ`: per-requester valid.
- `up_ready`  out  `N_REQ`: per-requester ready; at most one bit is high per cycle.
- `down_data`  out  `D_WIDTH`: registered payload.
- `down_src`  out  `$clog2(N_REQ)`: index of the requester that produced `down_data`.
- `down_valid`  out  1: registered valid.
- `down_ready`  in  1: downstream ready.

## Operation
- State: output register (`down_data`, `down_src`, `down_valid`), `owner` (last granted index), `cnt` (beats accepted from `owner` in the current burst, 0..MAX_BURST).
- `load_en = !down_valid | down_ready`.
- Lock condition: `cnt != 0 && cnt < MAX_BURST && up_valid[owner]`. While locked, the grant goes to `owner`.
- When not locked, the grant goes to the first set `up_valid` bit, searching from `owner+1` modulo `N_REQ` (wraps `N_REQ-1 → 0`) through `owner` itself, with `owner` last.
- No `up_valid` bit set: no grant, all `up_ready` low, `owner`/`cnt` hold.
- `up_ready[g] = load_en & (g == grant)`. A beat is accepted when `up_valid[g] & up_ready[g]`.
- On accept:
  - load `down_data ← up_data[g]`, `down_src ← g`, `down_valid ← 1`, `owner ← g`.
  - `cnt ← (g == owner && cnt < MAX_BURST) ? cnt+1 : 1`.
  - A new grant to the same owner after `cnt` reached `MAX_BURST` restarts at 1.
- If `load_en` is true and nothing is accepted: `down_valid ← 0`.
- If the owner drops `up_valid` mid-burst, the lock breaks immediately and round-robin proceeds in the same cycle.
- Per-requester order is preserved. No beat is dropped or duplicated.

## Timing
- Reset (async assert): `down_valid=0`, `down_data=0`, `down_src=0`, `cnt=0`, `owner=N_REQ-1`, so requester 0 has first priority. All `up_ready` are 0 while `rst` is high.
- Latency: a beat accepted on edge k is presented on `down_*` after edge k.
- Throughput: 1 beat/cycle sustained, including across grant changes and re-grants, with no bubbles.
- `up_ready` is combinational from `up_valid`, `down_ready`, and state. There is no combinational path from `up_data` to any output.
- Backpressure: while `down_valid & !down_ready`, `down_data`/`down_src` are stable, all `up_ready` are 0, and `owner`/`cnt` hold.
- Reset mid-operation: a beat held in the output register is discarded. Upstream beats not yet handshaken are unaffected.

## Structure
- Shared package `arb_pkg`: `localparam`-style function `idx_w(n)` returning `$clog2(n)` (minimum 1). It is used for `down_src` and `owner`.
- One combinational sub-module, `rr_priority_pick`: inputs are `req[N_REQ]` and `start` index; outputs are `gnt_idx` and `gnt_any`. It does a rotating find-first with wrap.
- The top holds the lock logic, `cnt`, `owner`, and the output register.

## Test plan
- Defaults; `up_valid=2'b11` constant, `down_ready=1`; A sends 0x01..0x08, B sends 0x21..0x28. Expect `down_src` 0,0,0,0,1,1,1,1,0…, data 0x01–0x04, 0x21–0x24, 0x05…, with no bubble cycles.
- Only requester 1 valid, 6 beats 0x10..0x15, `down_ready=1`. Expect 6 consecutive `down_valid` cycles, `down_src=1`, and no gap at the `cnt=4` re-grant.
- Stream running, `down_ready=0` for 3 cycles while `down_data=0x03`. Expect `down_data` held at 0x03, `up_ready=0`, `cnt` unchanged. After release, the next beat is 0x04.
- Both valid; A drops `up_valid` after 2 beats (`cnt=2`). Expect the next cycle to grant B with `cnt=1`. B holds 4 beats, then A regains the grant if valid.
- Assert `rst` mid-burst with `down_valid=1`. Expect `down_valid=0` before the next clock edge. After release with both valid, requester 0 is granted first.
- `N_REQ=4`, `MAX_BURST=1`, all valid: `down_src` 0,1,2,3,0… Then deassert req 2: `down_src` 0,1,3,0,1,3…
